// File: rtl/mat_loader.sv
// rtl/mat_loader.sv - streams two row-major matrices into registers and holds them for a multiplier
// Optional i_last framing checks enabled by defining MAT_LOADER_LAST_CHECK_EN.
module mat_loader #(
  parameter int BITWIDTH = 16,
  parameter int MAT1ROWS = 3,
  parameter int MAT1COLS = 3,
  parameter int MAT2COLS = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [BITWIDTH-1:0] i_data,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_last,
  output logic [BITWIDTH-1:0] o_mat1 [MAT1ROWS*MAT1COLS],
  output logic [BITWIDTH-1:0] o_mat2 [MAT1COLS*MAT2COLS],
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_err
);

  localparam int N1   = MAT1ROWS * MAT1COLS;
  localparam int N2   = MAT1COLS * MAT2COLS;
  localparam int NMAX = (N1 > N2) ? N1 : N2;
  localparam int IW   = (NMAX > 1) ? $clog2(NMAX) : 1;

  typedef enum logic [1:0] {LOAD1, LOAD2, HOLD} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx, idx_next;
  logic          accept;
  logic          final_beat;

  assign o_ready    = (state != HOLD);
  assign accept     = i_valid && o_ready;
  assign final_beat = (state == LOAD2) && (idx == IW'(N2 - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= LOAD1;
      idx     <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      o_valid <= (state_next == HOLD);
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      LOAD1: if (accept) begin
        if (idx == IW'(N1 - 1)) begin
          idx_next   = '0;
          state_next = LOAD2;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      LOAD2: if (accept) begin
        if (idx == IW'(N2 - 1)) begin
          idx_next   = '0;
          state_next = HOLD;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      HOLD: if (i_ready) begin
        idx_next   = '0;
        state_next = LOAD1;
      end
      default: begin
        idx_next   = '0;
        state_next = LOAD1;
      end
    endcase
`ifdef MAT_LOADER_LAST_CHECK_EN
    // An early i_last abandons the frame; the partially written beats stay in place.
    if (accept && i_last && !final_beat) begin
      idx_next   = '0;
      state_next = LOAD1;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N1; k++) o_mat1[k] <= '0;
      for (int k = 0; k < N2; k++) o_mat2[k] <= '0;
    end else if (accept) begin
      if (state == LOAD1) o_mat1[idx] <= i_data;
      if (state == LOAD2) o_mat2[idx] <= i_data;
    end
  end

`ifdef MAT_LOADER_LAST_CHECK_EN
  // Sticky: i_last must coincide exactly with the final matrix-2 beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else if (accept && (i_last != final_beat)) begin
      o_err <= 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = i_last;
  assign o_err       = 1'b0;
`endif

endmodule
